// File: rtl/aes_spi_pkg.sv
// Shared definitions for the SPI subordinate frame interface of the AES cores:
// header codes, frame-sequence states and the key payload length lookup.
package aes_spi_pkg;

  localparam logic [1:0] KS_128    = 2'b00;
  localparam logic [1:0] KS_192    = 2'b01;
  localparam logic [1:0] KS_256    = 2'b10;
  localparam logic [1:0] HDR_REKEY = 2'b11;

  localparam int HDR_BITS = 2;

  typedef enum logic [1:0] {
    S_KEY = 2'd0,
    S_MSG = 2'd1,
    S_OUT = 2'd2
  } frame_state_e;

  // Payload bits that follow the header of a key frame; 0 for the illegal code.
  function automatic logic [8:0] keylen(input logic [1:0] size);
    case (size)
      KS_128:  return 9'd128;
      KS_192:  return 9'd192;
      KS_256:  return 9'd256;
      default: return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the asynchronous SPI pins into the system clock domain and
// produces single-cycle sclk rise/fall and cs fall/rise strobes.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic sclk,
  input  logic sdi,
  output logic sdi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_s, sclk_s;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    cs_prev_d   = cs_s;
    sclk_prev_d = sclk_s;
  end

  // cs idles high so that leaving reset never looks like a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

endmodule

// File: rtl/spi_sub_frame_if.sv
// SPI subordinate front-end: deserialises key and message frames for the AES
// core and serialises the core result back on sdo, all on the system clock.
module spi_sub_frame_if
  import aes_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BLK_W       = 128,
  parameter int KEY_W_MAX   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 sclk,
  input  logic                 sdi,
  output logic                 sdo,
  output logic [KEY_W_MAX-1:0] key_o,
  output logic [1:0]           key_size_o,
  output logic                 key_valid_o,
  output logic [BLK_W-1:0]     blk_o,
  output logic                 blk_valid_o,
  input  logic [BLK_W-1:0]     res_i,
  input  logic                 res_valid_i,
  output logic                 frame_err_o
);

  logic sdi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .sclk     (sclk),
    .sdi      (sdi),
    .sdi_s    (sdi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise)
  );

  frame_state_e           state_q, state_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;
  logic                   rekey_ok_q, rekey_ok_d;
  logic                   res_loaded_q, res_loaded_d;
  logic                   out_has_res_q, out_has_res_d;
  logic [8:0]             cnt_q, cnt_d;
  logic [1:0]             hdr_q, hdr_d;
  logic [KEY_W_MAX-1:0]   rx_q, rx_d;
  logic [BLK_W+1:0]       tx_q, tx_d;
  logic [BLK_W-1:0]       res_q, res_d;
  logic [KEY_W_MAX-1:0]   key_q, key_d;
  logic [1:0]             key_size_q, key_size_d;
  logic                   key_valid_q, key_valid_d;
  logic [BLK_W-1:0]       blk_q, blk_d;
  logic                   blk_valid_q, blk_valid_d;
  logic                   err_q, err_d;

  logic       rise_act, fall_act, hdr_last, pay_last, hdr_err, rekey, abort;
  logic [1:0] hdr_full;
  logic [8:0] pay_len, frame_len, cnt_inc, key_shift;

  // Once a frame is done (complete, rejected or rekeyed) further sclk rises are ignored.
  assign rise_act  = sclk_rise & active_q & ~done_q;
  assign fall_act  = sclk_fall & active_q;
  assign hdr_full  = {hdr_q[0], sdi_s};
  assign pay_len   = (state_q == S_KEY) ? keylen(hdr_q) : 9'(BLK_W);
  assign frame_len = pay_len + 9'(HDR_BITS);
  assign cnt_inc   = cnt_q + 9'd1;
  assign key_shift = 9'(KEY_W_MAX) - pay_len;
  assign hdr_last  = rise_act & (cnt_q == 9'(HDR_BITS - 1));
  assign pay_last  = rise_act & (cnt_q >= 9'(HDR_BITS)) & (cnt_inc == frame_len);
  assign rekey     = hdr_last & (state_q == S_MSG) & (hdr_full == HDR_REKEY) & rekey_ok_q;
  assign hdr_err   = hdr_last & (((state_q == S_KEY) & (hdr_full == HDR_REKEY)) |
                                 ((state_q == S_MSG) & (hdr_full != KS_128) & ~rekey));
  assign abort     = cs_rise & active_q & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_KEY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rekey) begin
      state_d = S_KEY;
    end else if (pay_last) begin
      case (state_q)
        S_KEY:   state_d = S_MSG;
        S_MSG:   state_d = S_OUT;
        S_OUT:   state_d = S_MSG;
        default: state_d = S_KEY;
      endcase
    end
  end

  always_comb begin
    active_d      = active_q;
    done_d        = done_q;
    rekey_ok_d    = rekey_ok_q;
    res_loaded_d  = res_loaded_q;
    out_has_res_d = out_has_res_q;
    cnt_d         = cnt_q;
    hdr_d         = hdr_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    res_d         = res_q;
    key_d         = key_q;
    key_size_d    = key_size_q;
    key_valid_d   = 1'b0;
    blk_d         = blk_q;
    blk_valid_d   = 1'b0;
    err_d         = 1'b0;

    // A result arriving while a readout frame is in flight is dropped so sdo stays consistent.
    if (res_valid_i && !((state_q == S_OUT) && active_q)) begin
      res_d        = res_i;
      res_loaded_d = 1'b1;
    end

    if (cs_fall) begin
      active_d      = 1'b1;
      done_d        = 1'b0;
      cnt_d         = '0;
      hdr_d         = '0;
      rx_d          = '0;
      tx_d          = ((state_q == S_OUT) && res_loaded_q) ? {2'b00, res_q} : '0;
      out_has_res_d = res_loaded_q;
    end else begin
      if (rise_act) begin
        cnt_d = cnt_inc;
        if (cnt_q < 9'(HDR_BITS)) hdr_d = hdr_full;
        else                      rx_d  = {rx_q[KEY_W_MAX-2:0], sdi_s};
      end
      if (fall_act) tx_d = {tx_q[BLK_W:0], 1'b0};
      if (cs_rise) begin
        active_d = 1'b0;
        tx_d     = '0;
        err_d    = abort;
      end
      if (hdr_err) begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
      if (rekey) begin
        done_d     = 1'b1;
        rekey_ok_d = 1'b0;
      end
      if (pay_last) begin
        done_d = 1'b1;
        case (state_q)
          S_KEY: begin
            key_d       = rx_d << key_shift;
            key_size_d  = hdr_q;
            key_valid_d = 1'b1;
            rekey_ok_d  = 1'b0;
          end
          S_MSG: begin
            blk_d        = rx_d[BLK_W-1:0];
            blk_valid_d  = 1'b1;
            res_loaded_d = 1'b0;
          end
          S_OUT: begin
            rekey_ok_d = 1'b1;
            err_d      = ~out_has_res_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= 1'b0;
      done_q        <= 1'b0;
      rekey_ok_q    <= 1'b0;
      res_loaded_q  <= 1'b0;
      out_has_res_q <= 1'b0;
      cnt_q         <= '0;
      hdr_q         <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      res_q         <= '0;
      key_q         <= '0;
      key_size_q    <= '0;
      key_valid_q   <= 1'b0;
      blk_q         <= '0;
      blk_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      active_q      <= active_d;
      done_q        <= done_d;
      rekey_ok_q    <= rekey_ok_d;
      res_loaded_q  <= res_loaded_d;
      out_has_res_q <= out_has_res_d;
      cnt_q         <= cnt_d;
      hdr_q         <= hdr_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      res_q         <= res_d;
      key_q         <= key_d;
      key_size_q    <= key_size_d;
      key_valid_q   <= key_valid_d;
      blk_q         <= blk_d;
      blk_valid_q   <= blk_valid_d;
      err_q         <= err_d;
    end
  end

  assign sdo         = tx_q[BLK_W+1];
  assign key_o       = key_q;
  assign key_size_o  = key_size_q;
  assign key_valid_o = key_valid_q;
  assign blk_o       = blk_q;
  assign blk_valid_o = blk_valid_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_spi_sub_frame_if.sv
// Bench for spi_sub_frame_if: an SPI initiator drives a table of frames, a
// scoreboard queue holds the expected output pulses, plus reset/readout corners.
module tb_spi_sub_frame_if;

  localparam int HALF   = 8;
  localparam int EV_NONE = 0;
  localparam int EV_KEY  = 1;
  localparam int EV_BLK  = 2;
  localparam int EV_ERR  = 3;

  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] M1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] M2   = 128'hdeadbeef0123456789abcdeff0e1d2c3;
  localparam logic [127:0] R1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R2   = 128'h8899aabbccddeeff0011223344556677;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs = 1'b1;
  logic         sclk = 1'b0;
  logic         sdi = 1'b0;
  logic         sdo;
  logic [255:0] key_o;
  logic [1:0]   key_size_o;
  logic         key_valid_o;
  logic [127:0] blk_o;
  logic         blk_valid_o;
  logic [127:0] res_i = '0;
  logic         res_valid_i = 1'b0;
  logic         frame_err_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int           kind;
    logic [255:0] data;
    logic [1:0]   size;
  } ev_t;

  typedef struct {
    logic [1:0]   hdr;
    int           nbits;
    logic [255:0] pay;
    logic         pre_res;
    logic [127:0] res;
    logic [127:0] exp_rx;
    int           ev;
    logic [255:0] ev_data;
    logic [1:0]   ev_size;
  } vec_t;

  ev_t exp_q[$];

  spi_sub_frame_if dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .sclk       (sclk),
    .sdi        (sdi),
    .sdo        (sdo),
    .key_o      (key_o),
    .key_size_o (key_size_o),
    .key_valid_o(key_valid_o),
    .blk_o      (blk_o),
    .blk_valid_o(blk_valid_o),
    .res_i      (res_i),
    .res_valid_i(res_valid_i),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] hdr, input int nbits, input logic [255:0] pay,
                              input logic pre_res, input logic [127:0] res, input logic [127:0] exp_rx,
                              input int ev, input logic [255:0] ev_data, input logic [1:0] ev_size);
    vec_t v;
    v.hdr = hdr; v.nbits = nbits; v.pay = pay; v.pre_res = pre_res; v.res = res;
    v.exp_rx = exp_rx; v.ev = ev; v.ev_data = ev_data; v.ev_size = ev_size;
    return v;
  endfunction

  // Scoreboard: every output pulse must match the next expected event.
  always @(negedge clk) begin
    int  kind;
    ev_t e;
    if (rst_n && (key_valid_o || blk_valid_o || frame_err_o)) begin
      kind = frame_err_o ? EV_ERR : (key_valid_o ? EV_KEY : EV_BLK);
      check("excl_pulse", {255'd0, key_valid_o & blk_valid_o}, 256'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse kind=%0d required=none", kind);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 256'(kind), 256'(e.kind));
        if (e.kind == EV_KEY) begin
          check("key_o", key_o, e.data);
          check("key_size_o", 256'(key_size_o), 256'(e.size));
        end else if (e.kind == EV_BLK) begin
          check("blk_o", {blk_o, 128'd0}, e.data);
        end
      end
    end
  end

  task automatic pulse_res(input logic [127:0] r);
    @(negedge clk);
    res_i = r;
    res_valid_i = 1'b1;
    @(negedge clk);
    res_valid_i = 1'b0;
  endtask

  // SPI initiator, mode 0: sdi changes after sclk falls, sdo is sampled as sclk rises.
  // rst_at >= 0 asserts rst_n before that bit and returns with cs still low.
  task automatic spi_frame(input logic [1:0] hdr, input int nbits, input logic [255:0] pay,
                           input int rst_at, output logic [127:0] rx, output logic junk);
    rx = '0;
    junk = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    sdi = hdr[1];
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits + 2; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        return;
      end
      sdi = (i < 2) ? hdr[1-i] : pay[255-(i-2)];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      if (i >= 2 && i < 130) rx = {rx[126:0], sdo};
      else                   junk = junk | sdo;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    sdi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [127:0] rx;
    logic         junk;
    ev_t          e;
    if (v.pre_res) pulse_res(v.res);
    if (v.ev != EV_NONE) begin
      e.kind = v.ev;
      e.data = v.ev_data;
      e.size = v.ev_size;
      exp_q.push_back(e);
    end
    spi_frame(v.hdr, v.nbits, v.pay, -1, rx, junk);
    repeat (20) @(negedge clk);
    check($sformatf("v%0d_rx", idx), {rx, 128'd0}, {v.exp_rx, 128'd0});
    check($sformatf("v%0d_sdo_extra", idx), {255'd0, junk}, 256'd0);
    check($sformatf("v%0d_pending", idx), 256'(exp_q.size()), 256'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[14];
    logic [127:0] rx;
    logic         junk;

    vt[0]  = mk(2'b11, 4,   '1,               1'b0, '0, '0, EV_ERR,  '0,               2'b00);
    vt[1]  = mk(2'b00, 128, {K128, 128'd0},   1'b0, '0, '0, EV_KEY,  {K128, 128'd0},   2'b00);
    vt[2]  = mk(2'b00, 128, {M1, 128'd0},     1'b0, '0, '0, EV_BLK,  {M1, 128'd0},     2'b00);
    vt[3]  = mk(2'b00, 128, '1,               1'b1, R1, R1, EV_NONE, '0,               2'b00);
    vt[4]  = mk(2'b11, 8,   '1,               1'b0, '0, '0, EV_NONE, '0,               2'b00);
    vt[5]  = mk(2'b10, 256, K256,             1'b0, '0, '0, EV_KEY,  K256,             2'b10);
    vt[6]  = mk(2'b00, 128, {M2, 128'd0},     1'b0, '0, '0, EV_BLK,  {M2, 128'd0},     2'b00);
    vt[7]  = mk(2'b00, 132, '1,               1'b1, R2, R2, EV_NONE, '0,               2'b00);
    vt[8]  = mk(2'b11, 0,   '0,               1'b0, '0, '0, EV_NONE, '0,               2'b00);
    vt[9]  = mk(2'b01, 192, {K192, 64'd0},    1'b0, '0, '0, EV_KEY,  {K192, 64'd0},    2'b01);
    vt[10] = mk(2'b00, 68,  {M1, 128'd0},     1'b0, '0, '0, EV_ERR,  '0,               2'b00);
    vt[11] = mk(2'b00, 128, {M1, 128'd0},     1'b0, '0, '0, EV_BLK,  {M1, 128'd0},     2'b00);
    vt[12] = mk(2'b00, 128, '1,               1'b0, '0, '0, EV_ERR,  '0,               2'b00);
    vt[13] = mk(2'b00, 128, {M2, 128'd0},     1'b0, '0, '0, EV_BLK,  {M2, 128'd0},     2'b00);

    repeat (5) @(negedge clk);
    check("rst_key_o", key_o, 256'd0);
    check("rst_blk_o", {blk_o, 128'd0}, 256'd0);
    check("rst_flags", {250'd0, key_size_o, key_valid_o, blk_valid_o, frame_err_o, sdo}, 256'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_flags", {250'd0, key_size_o, key_valid_o, blk_valid_o, frame_err_o, sdo}, 256'd0);

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // A result offered mid-readout must not disturb the frame being shifted out.
    pulse_res(R1);
    fork
      spi_frame(2'b00, 128, '1, -1, rx, junk);
      begin
        repeat (600) @(negedge clk);
        pulse_res(R2);
      end
    join
    repeat (20) @(negedge clk);
    check("mid_res_rx", {rx, 128'd0}, {R1, 128'd0});
    check("mid_res_pending", 256'(exp_q.size()), 256'd0);

    // Rekey, then reset in the middle of the key frame.
    run_vec(mk(2'b11, 0, '0, 1'b0, '0, '0, EV_NONE, '0, 2'b00), 20);
    spi_frame(2'b00, 128, {K256[255:128], 128'd0}, 50, rx, junk);
    #1;
    check("midrst_key_o", key_o, 256'd0);
    check("midrst_blk_o", {blk_o, 128'd0}, 256'd0);
    check("midrst_flags", {250'd0, key_size_o, key_valid_o, blk_valid_o, frame_err_o, sdo}, 256'd0);
    @(negedge clk);
    cs = 1'b1;
    sclk = 1'b0;
    sdi = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_vec(mk(2'b00, 128, {K128, 128'd0}, 1'b0, '0, '0, EV_KEY, {K128, 128'd0}, 2'b00), 21);
    run_vec(mk(2'b00, 128, {M1, 128'd0},   1'b0, '0, '0, EV_BLK, {M1, 128'd0},   2'b00), 22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
